// File: rtl/ant_noc_router.sv
// rtl/ant_noc_router.sv - remote-page request router and iteration barrier for NUM_ANTS pagerank ants
// One query in flight; pending requests per ant are served round-robin.
module ant_noc_router #(
  parameter int NUM_ANTS  = 4,
  parameter int N         = 16,
  parameter int WIDTH     = 16,
  parameter int REPLY_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_ANTS-1:0]           req_valid,
  input  logic [6*NUM_ANTS-1:0]         req_page,
  output logic [6*NUM_ANTS-1:0]         query,
  output logic [NUM_ANTS-1:0]           query_valid,
  input  logic [WIDTH*NUM_ANTS-1:0]     reply,
  output logic [(WIDTH+6)*NUM_ANTS-1:0] response,
  output logic [NUM_ANTS-1:0]           resp_valid,
  input  logic [NUM_ANTS-1:0]           syc_out,
  output logic                          syc_in,
  output logic                          req_overflow
);

  localparam int AW = 2;

  typedef enum logic [1:0] {IDLE, QUERY, RESP} state_e;

  state_e                          state_q, state_d;
  logic [NUM_ANTS-1:0]             pend_q, pend_d;
  logic [NUM_ANTS-1:0][5:0]        page_q, page_d, query_q, query_d, req_page_a;
  logic [NUM_ANTS-1:0][WIDTH-1:0]  reply_a;
  logic [NUM_ANTS-1:0][WIDTH+5:0]  resp_q, resp_d;
  logic [AW-1:0]                   rr_q, rr_d, gnt_q, gnt_d, own_q, own_d, cnt_q, cnt_d;
  logic [AW-1:0]                   idx, cand;
  logic [NUM_ANTS-1:0]             qv_q, qv_d, rv_q, rv_d;
  logic                            syc_q, syc_d, ovf_q, ovf_d;
  logic                            found;
  logic [5:0]                      gpage;

  assign req_page_a   = req_page;
  assign reply_a      = reply;
  assign query        = query_q;
  assign query_valid  = qv_q;
  assign response     = resp_q;
  assign resp_valid   = rv_q;
  assign syc_in       = syc_q;
  assign req_overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    page_d  = page_q;
    query_d = query_q;
    resp_d  = resp_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    qv_d    = qv_q;
    rv_d    = rv_q;
    ovf_d   = ovf_q;
    found   = 1'b0;
    idx     = rr_q;
    cand    = '0;
    gpage   = '0;

    // Capture runs in every state; a strobe while still pending is dropped and flagged.
    for (int i = 0; i < NUM_ANTS; i++) begin
      if (req_valid[i]) begin
        if (pend_q[i]) begin
          ovf_d = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          page_d[i] = req_page_a[i];
        end
      end
    end

    syc_d = (&syc_out) && (state_q == IDLE) && !(|pend_q);

    case (state_q)
      IDLE: begin
        for (int k = 1; k <= NUM_ANTS; k++) begin
          cand = rr_q + AW'(k);
          if (!found && pend_q[cand]) begin
            found = 1'b1;
            idx   = cand;
          end
        end
        if (found) begin
          gpage          = page_q[idx];
          own_d          = AW'(gpage / 6'(N));
          query_d[own_d] = gpage;
          qv_d           = '0;
          qv_d[own_d]    = 1'b1;
          cnt_d          = AW'(REPLY_LAT - 1);
          rr_d           = idx;
          gnt_d          = idx;
          state_d        = QUERY;
        end
      end
      QUERY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          resp_d[gnt_q] = {reply_a[own_q], page_q[gnt_q]};
          rv_d[gnt_q]   = 1'b1;
          qv_d          = '0;
          pend_d[gnt_q] = 1'b0;
          state_d       = RESP;
        end
      end
      RESP: begin
        rv_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      page_q  <= '0;
      query_q <= '0;
      resp_q  <= '0;
      rr_q    <= AW'(NUM_ANTS - 1);
      gnt_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      qv_q    <= '0;
      rv_q    <= '0;
      syc_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      page_q  <= page_d;
      query_q <= query_d;
      resp_q  <= resp_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      qv_q    <= qv_d;
      rv_q    <= rv_d;
      syc_q   <= syc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ant_noc_router.sv
// tb/tb_ant_noc_router.sv - directed bench for ant_noc_router at REPLY_LAT 1 and 3
module tb_ant_noc_router;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [23:0] req_page;
  logic [63:0] reply;
  logic [3:0]  syc_out;

  logic [23:0] q1, q3;
  logic [3:0]  qv1, qv3, rv1, rv3;
  logic [87:0] resp1, resp3;
  logic        syc1, syc3, ovf1, ovf3;

  int total = 0;
  int bad   = 0;

  logic [5:0]  rr_pg  [5];
  logic [15:0] rr_dat [5];
  int          rr_ant [5];
  int          rr_own [5];

  always #5 clk = ~clk;

  ant_noc_router #(.NUM_ANTS(4), .N(16), .WIDTH(16), .REPLY_LAT(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_page(req_page),
    .query(q1), .query_valid(qv1), .reply(reply), .response(resp1),
    .resp_valid(rv1), .syc_out(syc_out), .syc_in(syc1), .req_overflow(ovf1)
  );

  ant_noc_router #(.NUM_ANTS(4), .N(16), .WIDTH(16), .REPLY_LAT(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_page(req_page),
    .query(q3), .query_valid(qv3), .reply(reply), .response(resp3),
    .resp_valid(rv3), .syc_out(syc_out), .syc_in(syc3), .req_overflow(ovf3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_page  = '0;
    reply     = '0;
    syc_out   = '0;
    tick();
    tick();
    chk("rst_qv", 64'(qv1), 64'h0);
    chk("rst_rv", 64'(rv1), 64'h0);
    chk("rst_q", 64'(q1), 64'h0);
    chk("rst_resp", 64'(|resp1), 64'h0);
    chk("rst_syc", 64'(syc1), 64'h0);
    chk("rst_ovf", 64'(ovf1), 64'h0);
    reset_n = 1'b1;

    // reset while the query is outstanding
    req_valid = 4'b0010;
    req_page[11:6] = 6'h23;
    tick();
    req_valid = '0;
    tick();
    chk("mid_grant_qv", 64'(qv1), 64'h4);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_qv", 64'(qv1), 64'h0);
    chk("mid_rst_q", 64'(q1), 64'h0);
    tick();
    chk("mid_rst_rv", 64'(rv1), 64'h0);
    reset_n = 1'b1;
    tick();
    chk("mid_after_rv", 64'(rv1), 64'h0);
    tick();
    chk("mid_after_qv", 64'(qv1), 64'h0);
    chk("mid_after_rv2", 64'(rv1), 64'h0);

    // single request, owner 2
    reply[47:32] = 16'h1234;
    req_valid = 4'b0001;
    req_page[5:0] = 6'h25;
    tick();
    req_valid = '0;
    tick();
    chk("single_qv", 64'(qv1), 64'h4);
    chk("single_q2", 64'(q1[17:12]), 64'h25);
    chk("single_rv_early", 64'(rv1), 64'h0);
    tick();
    chk("single_rv", 64'(rv1), 64'h1);
    chk("single_resp", 64'(resp1[21:0]), 64'({16'h1234, 6'h25}));
    chk("single_qv_off", 64'(qv1), 64'h0);
    tick();
    chk("single_rv_off", 64'(rv1), 64'h0);
    chk("single_hold", 64'(resp1[21:0]), 64'({16'h1234, 6'h25}));

    // round robin from a fresh pointer, plus a repeat from ant0
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    reply = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
    rr_pg  = '{6'h10, 6'h20, 6'h30, 6'h00, 6'h05};
    rr_dat = '{16'hA111, 16'hA222, 16'hA333, 16'hA000, 16'hA000};
    rr_ant = '{0, 1, 2, 3, 0};
    rr_own = '{1, 2, 3, 0, 0};
    req_valid = 4'b1111;
    req_page  = {6'h00, 6'h30, 6'h20, 6'h10};
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_qv", 64'(qv1), 64'(1) << rr_own[k]);
      chk("rr_q", 64'(q1[6*rr_own[k] +: 6]), 64'(rr_pg[k]));
      tick();
      chk("rr_rv", 64'(rv1), 64'(1) << rr_ant[k]);
      chk("rr_resp", 64'(resp1[22*rr_ant[k] +: 22]), 64'({rr_dat[k], rr_pg[k]}));
      if (k == 0) begin
        req_valid = 4'b0001;
        req_page[5:0] = 6'h05;
      end
      tick();
      req_valid = '0;
      chk("rr_rv_off", 64'(rv1), 64'h0);
    end
    chk("rr_no_ovf", 64'(ovf1), 64'h0);

    // second strobe from ant2 before its response
    req_valid = 4'b0100;
    req_page[17:12] = 6'h12;
    tick();
    req_valid = '0;
    tick();
    chk("ovf_qv", 64'(qv1), 64'h2);
    req_valid = 4'b0100;
    req_page[17:12] = 6'h3F;
    tick();
    req_valid = '0;
    chk("ovf_rv", 64'(rv1), 64'h4);
    chk("ovf_resp", 64'(resp1[65:44]), 64'({16'hA111, 6'h12}));
    chk("ovf_flag", 64'(ovf1), 64'h1);
    tick();
    chk("ovf_rv_off", 64'(rv1), 64'h0);
    tick();
    chk("ovf_no_regrant", 64'(qv1), 64'h0);
    tick();
    chk("ovf_no_resp", 64'(rv1), 64'h0);
    chk("ovf_sticky", 64'(ovf1), 64'h1);

    // REPLY_LAT=3 instance: reply sampled three cycles after query_valid
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("l3_ovf_cleared", 64'(ovf3), 64'h0);
    reply[31:16] = 16'h1111;
    req_valid = 4'b1000;
    req_page[23:18] = 6'h1A;
    tick();
    req_valid = '0;
    tick();
    chk("l3_qv", 64'(qv3), 64'h2);
    chk("l3_q1", 64'(q3[11:6]), 64'h1A);
    reply[31:16] = 16'h2222;
    tick();
    chk("l3_rv_e2", 64'(rv3), 64'h0);
    chk("l3_qv_e2", 64'(qv3), 64'h2);
    tick();
    chk("l3_rv_e3", 64'(rv3), 64'h0);
    reply[31:16] = 16'h4444;
    tick();
    chk("l3_rv_e4", 64'(rv3), 64'h8);
    chk("l3_resp", 64'(resp3[87:66]), 64'({16'h4444, 6'h1A}));
    chk("l3_qv_off", 64'(qv3), 64'h0);

    // barrier held off while a request is in flight
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    syc_out = '0;
    req_valid = 4'b0001;
    req_page[5:0] = 6'h05;
    tick();
    req_valid = '0;
    syc_out = 4'b1111;
    tick();
    chk("bar_pend", 64'(syc1), 64'h0);
    tick();
    chk("bar_query", 64'(syc1), 64'h0);
    tick();
    chk("bar_resp", 64'(syc1), 64'h0);
    tick();
    chk("bar_release", 64'(syc1), 64'h1);
    syc_out = 4'b0111;
    tick();
    chk("bar_drop", 64'(syc1), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
